cpu_exec_core: RTL and testbench
================================

CPU_EXEC_CORE -- requirements
Module: cpu_exec_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ins, input, 16: current instruction; opcode = ins[15:13].
REQ-005 SHALL have port reg_read_data_1, input, 16: register operand A, selected by ins[12:9].
REQ-006 SHALL have port reg_read_data_2, input, 16: register operand B, selected by ins[8:5].
REQ-007 SHALL have port pc, output, 16: current program counter (registered).
REQ-008 SHALL have port alu_out, output, 16: ALU result (also the memory address).
REQ-009 SHALL have port zero, output, 1: high when alu_out == 16'h0000.
REQ-010 SHALL have port imm, output, 16: ins[4:0] sign-extended to 16 bits.
REQ-011 SHALL have ports jump, branch, mem_write, alu_src, reg_write, reg_dst, mem_to_reg, each output, 1: decoded control signals.
REQ-012 SHALL have port reg_write_dest, output, 4: ins[4:1] when reg_dst=0, else ins[8:5].

Function
REQ-013 SHALL decode the opcode combinationally into control signals (j=jump, b=branch, mw=mem_write, as=alu_src, rw=reg_write, rd=reg_dst, mr=mem_to_reg); all unlisted signals are 0:
- 000 LW: as, rw, rd, mr.
- 001 SW: as, mw.
- 010 ADD: rw.
- 011 SUB: rw.
- 100 AND: rw.
- 101 OR: rw.
- 110 BEQ: b.
- 111 JMP: j.
REQ-014 SHALL select ALU operand b = imm when alu_src=1, else reg_read_data_2; operand a = reg_read_data_1.
REQ-015 SHALL compute alu_out combinationally from the opcode, with all arithmetic 16-bit modulo 2^16 and carry/overflow discarded:
- 000, 001, 010, 111: a+b.
- 011, 110: a-b.
- 100: a&b.
- 101: a|b.
REQ-016 SHALL compute next PC with the following priority:
- jump=1: {pc[15:13], ins[12:0]}.
- else branch=1 and zero=1: pc + 2 + imm.
- else: pc + 2.
- The branch offset is in bytes, not shifted.
REQ-017 SHALL load the PC with next PC on every rising clk edge when reset=0; there is no stall or enable input.
REQ-018 SHALL wrap PC arithmetic modulo 2^16; for example, pc=16'hFFFE with no jump or branch becomes 16'h0000.
REQ-019 SHALL treat a negative imm as a backward branch; for example, ins[4:0]=5'b11110 gives imm=16'hFFFE.
REQ-020 SHALL take BEQ only when zero=1; otherwise BEQ falls through to pc+2.
REQ-021 SHALL give jump priority over branch; the two cannot both be asserted for a legal opcode.
REQ-022 SHALL have zero-cycle latency for all outputs except pc, which changes one clock after the instruction that determines it.

Reset
REQ-023 SHALL load pc <= RESET_PC on a rising clk edge while reset=1.
REQ-024 SHALL force all control outputs (jump, branch, mem_write, alu_src, reg_write, reg_dst, mem_to_reg) to 0 combinationally while reset=1, regardless of ins.
REQ-025 SHALL leave alu_out, zero and imm as functions of the inputs during reset; with alu_src=0, alu_out = reg_read_data_1 op reg_read_data_2.
REQ-026 SHALL, when reset is asserted mid-program, override any pending jump or branch; the first cycle after release fetches from RESET_PC.

Verification
REQ-027 Reset then sequential fetch: hold reset 2 cycles, release, ins=ADD -> pc sequence 0000, 0002, 0004, 0006; reg_write=1, reg_dst=0.
REQ-028 ALU: ADD with a=16'h7FFF, b=16'h0001 -> alu_out=16'h8000, zero=0; SUB with a=b=16'h1234 -> alu_out=16'h0000, zero=1; AND 16'hF0F0 & 16'h0FF0 -> 16'h00F0; OR -> 16'hFFF0.
REQ-029 LW/SW: ins={000,rs,rt,5'b10000}, a=16'h0100 -> alu_src=1, imm=16'hFFF0, alu_out=16'h00F0, mem_to_reg=1, reg_write_dest=rt; opcode 001 -> mem_write=1, reg_write=0.
REQ-030 BEQ: pc=16'h0010, a=b, ins[4:0]=5'b00100 -> next pc=16'h0016; a!=b -> 16'h0012; ins[4:0]=5'b11100 with a=b -> 16'h000E.
REQ-031 JMP: pc=16'hA010, ins={111, 13'h0123} -> next pc=16'hA123; assert reset in the same cycle -> pc=RESET_PC and jump=0.
REQ-032 Wrap: pc=16'hFFFE with ADD -> next pc=16'h0000.

Source files
------------

// File: rtl/cpu_exec_core.sv
// Single-cycle execute core: opcode decode, ALU and program-counter update.
// Latency: all outputs are combinational from ins/operands except pc, which updates one clock later.
// Backpressure: none; the PC advances on every rising clock edge outside reset.
module cpu_exec_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ins,
  input  logic [15:0] reg_read_data_1,
  input  logic [15:0] reg_read_data_2,
  output logic [15:0] pc,
  output logic [15:0] alu_out,
  output logic        zero,
  output logic [15:0] imm,
  output logic        jump,
  output logic        branch,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [3:0]  reg_write_dest
);

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_SW  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_BEQ = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  opcode_t     opcode;
  logic [15:0] alu_b;
  logic [15:0] pc_seq;
  logic [15:0] next_pc;

  assign opcode = opcode_t'(ins[15:13]);

  // Byte-granular immediate; negative values give backward branches.
  assign imm = {{11{ins[4]}}, ins[4:0]};

  // Decode opcode into control strobes; reset holds every strobe low so no
  // write or redirect can escape while the core is being reset.
  always_comb begin
    jump       = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    if (!reset) begin
      case (opcode)
        OP_LW: begin
          alu_src    = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          mem_to_reg = 1'b1;
        end
        OP_SW: begin
          alu_src   = 1'b1;
          mem_write = 1'b1;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR: reg_write = 1'b1;
        OP_BEQ: branch = 1'b1;
        OP_JMP: jump   = 1'b1;
        default: ;
      endcase
    end
  end

  assign reg_write_dest = reg_dst ? ins[8:5] : ins[4:1];
  assign alu_b          = alu_src ? imm : reg_read_data_2;

  // ALU: opcode selects the operation directly; BEQ subtracts so zero flags equality.
  always_comb begin
    alu_out = 16'h0000;
    case (opcode)
      OP_SUB, OP_BEQ: alu_out = reg_read_data_1 - alu_b;
      OP_AND:         alu_out = reg_read_data_1 & alu_b;
      OP_OR:          alu_out = reg_read_data_1 | alu_b;
      default:        alu_out = reg_read_data_1 + alu_b;
    endcase
  end

  assign zero   = (alu_out == 16'h0000);
  assign pc_seq = pc + 16'd2;

  // Next-PC select: jump stays within the current 8 KB region, taken branch
  // offsets from the sequential PC, otherwise fall through; all wraps mod 2^16.
  always_comb begin
    next_pc = pc_seq;
    if (jump) begin
      next_pc = {pc[15:13], ins[12:0]};
    end else if (branch && zero) begin
      next_pc = pc_seq + imm;
    end
  end

  // Program counter register; reset wins over any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_cpu_exec_core.sv
module tb_cpu_exec_core;

  logic        clk;
  logic        reset;
  logic [15:0] ins;
  logic [15:0] reg_read_data_1;
  logic [15:0] reg_read_data_2;
  logic [15:0] pc;
  logic [15:0] alu_out;
  logic        zero;
  logic [15:0] imm;
  logic        jump;
  logic        branch;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic [3:0]  reg_write_dest;

  int passed;
  int total;
  logic [15:0] exp_pc;
  logic [15:0] d;
  logic [15:0] off;

  cpu_exec_core #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .ins             (ins),
    .reg_read_data_1 (reg_read_data_1),
    .reg_read_data_2 (reg_read_data_2),
    .pc              (pc),
    .alu_out         (alu_out),
    .zero            (zero),
    .imm             (imm),
    .jump            (jump),
    .branch          (branch),
    .mem_write       (mem_write),
    .alu_src         (alu_src),
    .reg_write       (reg_write),
    .reg_dst         (reg_dst),
    .mem_to_reg      (mem_to_reg),
    .reg_write_dest  (reg_write_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;

    // Reset held two cycles with a JMP on ins: strobes must stay low.
    reset = 1'b1;
    ins = {3'b111, 13'h0123};
    reg_read_data_1 = 16'h0005;
    reg_read_data_2 = 16'h0003;
    #1;
    chk("rst_jump", {15'd0, jump}, 16'd0);
    chk("rst_branch", {15'd0, branch}, 16'd0);
    chk("rst_alu_src", {15'd0, alu_src}, 16'd0);
    chk("rst_alu_out", alu_out, 16'h0008);
    step();
    step();
    chk("rst_pc", pc, 16'h0000);

    // Sequential fetch with ADD.
    reset = 1'b0;
    ins = {3'b010, 4'h1, 4'h2, 5'b00110};
    #1;
    chk("add_reg_write", {15'd0, reg_write}, 16'd1);
    chk("add_reg_dst", {15'd0, reg_dst}, 16'd0);
    chk("add_dest", {12'd0, reg_write_dest}, 16'h0003);
    chk("seq_pc0", pc, 16'h0000);
    step(); chk("seq_pc1", pc, 16'h0002);
    step(); chk("seq_pc2", pc, 16'h0004);
    step(); chk("seq_pc3", pc, 16'h0006);

    // ALU patterns.
    reg_read_data_1 = 16'h7FFF; reg_read_data_2 = 16'h0001; #1;
    chk("add_ovf", alu_out, 16'h8000);
    chk("add_zero", {15'd0, zero}, 16'd0);
    ins = {3'b011, 4'h1, 4'h2, 5'b00000};
    reg_read_data_1 = 16'h1234; reg_read_data_2 = 16'h1234; #1;
    chk("sub_eq", alu_out, 16'h0000);
    chk("sub_zero", {15'd0, zero}, 16'd1);
    ins = {3'b100, 4'h1, 4'h2, 5'b00000};
    reg_read_data_1 = 16'hF0F0; reg_read_data_2 = 16'h0FF0; #1;
    chk("and", alu_out, 16'h00F0);
    ins = {3'b101, 4'h1, 4'h2, 5'b00000}; #1;
    chk("or", alu_out, 16'hFFF0);

    // LW / SW with negative immediate.
    ins = {3'b000, 4'h1, 4'h5, 5'b10000};
    reg_read_data_1 = 16'h0100; reg_read_data_2 = 16'h7777; #1;
    chk("lw_alu_src", {15'd0, alu_src}, 16'd1);
    chk("lw_imm", imm, 16'hFFF0);
    chk("lw_addr", alu_out, 16'h00F0);
    chk("lw_mem_to_reg", {15'd0, mem_to_reg}, 16'd1);
    chk("lw_dest", {12'd0, reg_write_dest}, 16'h0005);
    ins = {3'b001, 4'h1, 4'h5, 5'b10000}; #1;
    chk("sw_mem_write", {15'd0, mem_write}, 16'd1);
    chk("sw_reg_write", {15'd0, reg_write}, 16'd0);
    chk("sw_addr", alu_out, 16'h00F0);

    // BEQ taken forward, not taken, taken backward (all from pc=0010).
    ins = {3'b111, 13'h0010}; step();
    chk("jmp_0010", pc, 16'h0010);
    ins = {3'b110, 4'h1, 4'h2, 5'b00100};
    reg_read_data_1 = 16'h0055; reg_read_data_2 = 16'h0055; #1;
    chk("beq_branch", {15'd0, branch}, 16'd1);
    step();
    chk("beq_fwd", pc, 16'h0016);
    ins = {3'b111, 13'h0010}; step();
    ins = {3'b110, 4'h1, 4'h2, 5'b00100};
    reg_read_data_2 = 16'h0056;
    step();
    chk("beq_not_taken", pc, 16'h0012);
    ins = {3'b111, 13'h0010}; step();
    ins = {3'b110, 4'h1, 4'h2, 5'b11100};
    reg_read_data_2 = 16'h0055; #1;
    chk("beq_imm_neg", imm, 16'hFFFC);
    step();
    chk("beq_back", pc, 16'h000E);

    // Backward branch below zero, then sequential wrap FFFE -> 0000.
    ins = {3'b110, 4'h1, 4'h2, 5'b10000}; step();
    chk("beq_to_0", pc, 16'h0000);
    ins = {3'b110, 4'h1, 4'h2, 5'b11100}; step();
    chk("beq_wrap", pc, 16'hFFFE);
    ins = {3'b010, 4'h1, 4'h2, 5'b00000}; step();
    chk("add_wrap", pc, 16'h0000);

    // Walk backward to A010 with taken BEQs (a=b=0), tracking the PC in the bench.
    reg_read_data_1 = 16'h0000; reg_read_data_2 = 16'h0000;
    exp_pc = 16'h0000;
    for (int i = 0; i < 4000 && exp_pc != 16'hA010; i++) begin
      d = exp_pc - 16'hA010;
      if (d >= 16'd14) off = 16'hFFF0;
      else off = 16'h0000 - d - 16'd2;
      ins = {3'b110, 4'h1, 4'h2, off[4:0]};
      exp_pc = exp_pc + 16'd2 + off;
      step();
    end
    chk("walk_pc", pc, 16'hA010);

    // JMP keeps the upper three PC bits.
    ins = {3'b111, 13'h0123}; #1;
    chk("jmp_jump", {15'd0, jump}, 16'd1);
    step();
    chk("jmp_region", pc, 16'hA123);
    ins = {3'b111, 13'h0010}; step();
    chk("jmp_back", pc, 16'hA010);

    // Reset asserted alongside a JMP overrides it.
    reset = 1'b1;
    ins = {3'b111, 13'h0123}; #1;
    chk("rst_mid_jump", {15'd0, jump}, 16'd0);
    step();
    chk("rst_mid_pc", pc, 16'h0000);
    reset = 1'b0;
    ins = {3'b010, 4'h1, 4'h2, 5'b00000}; step();
    chk("post_rst_pc", pc, 16'h0002);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
